// File: rtl/conv_encoder_framer_if.sv
// Handshake bundle for conv_encoder_framer.
//   in_valid/in_bit/in_last/in_ready : information-bit stream (into the encoder)
//   sym_valid/sym/sym_last/sym_ready : code-symbol stream (out of the encoder)
// The slave modport is the encoder's view; master is the surrounding logic.
interface conv_encoder_framer_if;
   logic       in_valid;
   logic       in_bit;
   logic       in_last;
   logic       in_ready;
   logic       sym_valid;
   logic [1:0] sym;
   logic       sym_last;
   logic       sym_ready;

   modport master (
      output in_valid, in_bit, in_last, sym_ready,
      input  in_ready, sym_valid, sym, sym_last
   );

   modport slave (
      input  in_valid, in_bit, in_last, sym_ready,
      output in_ready, sym_valid, sym, sym_last
   );
endinterface

// File: rtl/conv_encoder_framer.sv
// Rate-1/2 convolutional encoder with framing, feeding the Viterbi decoder.
// Each accepted information bit yields one 2-bit symbol; optionally K-1 zero
// tail bits terminate the trellis in state 0. Frames longer than the decoder
// buffer are truncated and the excess input is swallowed.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : slave side of conv_encoder_framer_if (bit in, symbol out)
//   frame_len   : symbols in the last completed frame
//   frame_done  : one-cycle pulse after the final symbol is accepted
//   overflow    : sticky, a frame was truncated at capacity
//
// state  | meaning
// S_IDLE | waiting for the first bit of a frame, st and count are zero
// S_DATA | accepting data bits, one symbol each
// S_TAIL | emitting K-1 zero-input flush symbols, input stalled
// S_DROP | frame truncated, discarding input up to and including in_last
module conv_encoder_framer #(
   parameter int             K        = 3,
   parameter logic [K-1:0]   G0       = 3'b111,
   parameter logic [K-1:0]   G1       = 3'b101,
   parameter int             TAIL     = 1,
   parameter int             MAX_SYMS = 256
) (
   input  logic                        clk,
   input  logic                        rst_n,
   conv_encoder_framer_if.slave        bus,
   output logic [7:0]                  frame_len,
   output logic                        frame_done,
   output logic                        overflow
);

   localparam int         CAP      = (MAX_SYMS > 255) ? 255 : MAX_SYMS;
   localparam int         L        = CAP - TAIL * (K - 1);
   localparam logic [7:0] LAST_IDX = 8'(L - 1);
   localparam int         TW       = (K > 2) ? $clog2(K - 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL, S_DROP} state_t;

   state_t          state;
   logic [K-2:0]    st;
   logic [7:0]      cnt;
   logic [7:0]      len_pend;
   logic [TW-1:0]   tail_left;
   logic            trunc;

   logic            load;
   logic            xfer_last;
   logic [K-1:0]    r_in;
   logic [1:0]      sym_n;
   logic            cap_hit;

   assign load      = !bus.sym_valid || bus.sym_ready;
   assign xfer_last = bus.sym_valid && bus.sym_ready && bus.sym_last;
   assign bus.in_ready = load && (state != S_TAIL);

   // Tail bits are zero; otherwise the offered bit enters the register.
   assign r_in    = {st, (state == S_TAIL) ? 1'b0 : bus.in_bit};
   assign sym_n   = {^(G0 & r_in), ^(G1 & r_in)};
   // cnt equals the number of data bits already accepted in this frame.
   assign cap_hit = (cnt == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         st            <= '0;
         cnt           <= '0;
         len_pend      <= '0;
         tail_left     <= '0;
         trunc         <= 1'b0;
         bus.sym_valid <= 1'b0;
         bus.sym       <= '0;
         bus.sym_last  <= 1'b0;
         frame_len     <= '0;
         frame_done    <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         frame_done <= xfer_last;
         if (xfer_last) frame_len <= len_pend;
         if (load) bus.sym_valid <= 1'b0;

         case (state)
            S_IDLE, S_DATA: begin
               if (bus.in_valid && load) begin
                  bus.sym_valid <= 1'b1;
                  bus.sym       <= sym_n;
                  st            <= r_in[K-2:0];
                  cnt           <= cnt + 8'd1;
                  state         <= S_DATA;
                  bus.sym_last  <= 1'b0;
                  if (bus.in_last || cap_hit) begin
                     if (!bus.in_last) overflow <= 1'b1;
                     if (TAIL != 0) begin
                        state     <= S_TAIL;
                        tail_left <= TW'(K - 2);
                        trunc     <= !bus.in_last;
                     end else begin
                        bus.sym_last <= 1'b1;
                        len_pend     <= cnt + 8'd1;
                        st           <= '0;
                        cnt          <= '0;
                        state        <= bus.in_last ? S_IDLE : S_DROP;
                     end
                  end
               end
            end
            S_TAIL: begin
               if (load) begin
                  bus.sym_valid <= 1'b1;
                  bus.sym       <= sym_n;
                  st            <= r_in[K-2:0];
                  cnt           <= cnt + 8'd1;
                  bus.sym_last  <= 1'b0;
                  if (tail_left == '0) begin
                     bus.sym_last <= 1'b1;
                     len_pend     <= cnt + 8'd1;
                     st           <= '0;
                     cnt          <= '0;
                     state        <= trunc ? S_DROP : S_IDLE;
                  end else begin
                     tail_left <= tail_left - 1'b1;
                  end
               end
            end
            S_DROP: begin
               if (bus.in_valid && load && bus.in_last) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_encoder_framer.sv
module tb_conv_encoder_framer;

   localparam int       K  = 3;
   localparam bit [2:0] G0 = 3'b111;
   localparam bit [2:0] G1 = 3'b101;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv_encoder_framer_if ifa ();
   conv_encoder_framer_if ifb ();

   logic [7:0] len_a, len_b;
   logic       done_a, done_b, ovf_a, ovf_b;

   conv_encoder_framer #(.K(K), .G0(G0), .G1(G1), .TAIL(1), .MAX_SYMS(256)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa),
      .frame_len(len_a), .frame_done(done_a), .overflow(ovf_a));

   conv_encoder_framer #(.K(K), .G0(G0), .G1(G1), .TAIL(0), .MAX_SYMS(256)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb),
      .frame_len(len_b), .frame_done(done_b), .overflow(ovf_b));

   int n_cmp = 0;
   int n_bad = 0;

   bit fbits[$];
   int m_sym[$];
   int exp_a[$];
   int explen[$];
   bit done_exp = 1'b0;
   int len_exp = 0;
   int rmode = 0;

   task automatic chk(input string nm, input int act, input int want);
      n_cmp++;
      if (act != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, want);
      end
   endtask

   // Reference: keep a history of the last K input bits and take the
   // generator-weighted parity, after clipping the data to capacity.
   function automatic void model(input int n, input int tail);
      int       lim;
      int       nd;
      int       s1;
      int       s0;
      bit       h[K];
      bit [2:0] g0v;
      bit [2:0] g1v;
      g0v = G0;
      g1v = G1;
      lim = 255 - tail * (K - 1);
      nd  = (n < lim) ? n : lim;
      m_sym.delete();
      foreach (h[j]) h[j] = 1'b0;
      for (int i = 0; i < nd + tail * (K - 1); i++) begin
         for (int j = K - 1; j > 0; j--) h[j] = h[j-1];
         h[0] = (i < nd) ? fbits[i] : 1'b0;
         s1 = 0;
         s0 = 0;
         for (int j = 0; j < K; j++) begin
            s1 = s1 ^ int'(g0v[j] & h[j]);
            s0 = s0 ^ int'(g1v[j] & h[j]);
         end
         m_sym.push_back(s1 * 2 + s0);
      end
   endfunction

   task automatic pin(input string nm, input int tail, input int want[$]);
      model(fbits.size(), tail);
      chk({nm, "_count"}, m_sym.size(), want.size());
      for (int i = 0; i < want.size() && i < m_sym.size(); i++)
         chk($sformatf("%s_sym%0d", nm, i), m_sym[i], want[i]);
   endtask

   // Symbol-side compare for DUT A: every handshake is checked against the
   // expected stream, plus frame_done/frame_len every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("a_frame_done", int'(done_a), int'(done_exp));
            if (done_exp) chk("a_frame_len", int'(len_a), len_exp);
            done_exp = 1'b0;
            if (ifa.sym_valid && !ifa.sym_ready)
               chk("a_in_ready_stall", int'(ifa.in_ready), 0);
            if (ifa.sym_valid && ifa.sym_ready) begin
               if (exp_a.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL a_extra_symbol: got sym %0d last %0d, expected none",
                           ifa.sym, ifa.sym_last);
               end else begin
                  chk("a_sym_last", int'({ifa.sym_last, ifa.sym}), exp_a.pop_front());
                  if (ifa.sym_last) begin
                     done_exp = 1'b1;
                     len_exp  = (explen.size() != 0) ? explen.pop_front() : -1;
                  end
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       ifa.sym_ready = 1'b1;
            1:       ifa.sym_ready = !ifa.sym_ready;
            default: ifa.sym_ready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   task automatic send_a(input int gap);
      int n;
      int t;
      int w;
      n = fbits.size();
      model(n, 1);
      for (int i = 0; i < m_sym.size(); i++)
         exp_a.push_back(((i == m_sym.size() - 1) ? 4 : 0) | m_sym[i]);
      explen.push_back(m_sym.size());
      for (int i = 0; i < n; i++) begin
         w = (gap > 0) ? $urandom_range(0, gap) : 0;
         repeat (w) begin @(posedge clk); #1; end
         ifa.in_valid = 1'b1;
         ifa.in_bit   = fbits[i];
         ifa.in_last  = (i == n - 1);
         t = 0;
         forever begin
            @(negedge clk);
            if (ifa.in_ready || t > 200) break;
            t++;
         end
         if (t > 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL a_in_ready_timeout: bit %0d not accepted, expected accept", i);
         end
         @(posedge clk);
         #1;
         ifa.in_valid = 1'b0;
         ifa.in_last  = 1'b0;
      end
   endtask

   task automatic drain_a();
      int t;
      t = 0;
      while ((exp_a.size() != 0 || done_exp) && t < 3000) begin
         @(posedge clk);
         t++;
      end
      chk("a_drain_left", exp_a.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic run_b();
      int n;
      n = fbits.size();
      model(n, 0);
      for (int i = 0; i < n; i++) begin
         ifb.in_valid = 1'b1;
         ifb.in_bit   = fbits[i];
         ifb.in_last  = (i == n - 1);
         @(posedge clk);
         #1;
         ifb.in_valid = 1'b0;
         ifb.in_last  = 1'b0;
         @(negedge clk);
         chk("b_sym_valid", int'(ifb.sym_valid), 1);
         chk("b_sym_last", int'({ifb.sym_last, ifb.sym}), ((i == n - 1) ? 4 : 0) | m_sym[i]);
      end
      @(negedge clk);
      chk("b_frame_done", int'(done_b), 1);
      chk("b_frame_len", int'(len_b), n);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      ifa.in_valid = 1'b0; ifa.in_bit = 1'b0; ifa.in_last = 1'b0; ifa.sym_ready = 1'b1;
      ifb.in_valid = 1'b0; ifb.in_bit = 1'b0; ifb.in_last = 1'b0; ifb.sym_ready = 1'b1;

      // Model pinned to hand-worked sequences.
      fbits = '{0, 1, 0, 1, 0, 1, 0, 1};
      pin("pin_alt", 1, '{0, 3, 2, 0, 2, 0, 2, 0, 2, 3});
      fbits = '{1};
      pin("pin_imp_tail", 1, '{3, 2, 3});
      pin("pin_imp_notail", 0, '{3});
      fbits = '{1, 1};
      pin("pin_11", 1, '{3, 1, 1, 3});
      fbits.delete();
      for (int i = 0; i < 300; i++) fbits.push_back(1'b1);
      model(300, 1);
      chk("pin_ovf_count", m_sym.size(), 255);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_sym_valid", int'(ifa.sym_valid), 0);
      chk("rst_frame_len", int'(len_a), 0);
      chk("rst_overflow", int'(ovf_a), 0);
      chk("rst_in_ready", int'(ifa.in_ready), 1);
      @(posedge clk);
      #1;

      // Alternating frame, continuous ready.
      rmode = 0;
      fbits = '{0, 1, 0, 1, 0, 1, 0, 1};
      send_a(0);
      drain_a();
      chk("alt_frame_len", int'(len_a), 10);

      // Same frame under toggling backpressure.
      rmode = 1;
      send_a(0);
      drain_a();

      // Impulse.
      rmode = 0;
      fbits = '{1};
      send_a(0);
      drain_a();
      chk("imp_frame_len", int'(len_a), 3);

      // Back-to-back frames.
      fbits = '{1, 1};
      send_a(0);
      fbits = '{1};
      send_a(0);
      drain_a();

      // Random frames with random gaps and backpressure.
      for (int f = 0; f < 6; f++) begin
         n = $urandom_range(1, 40);
         fbits.delete();
         for (int i = 0; i < n; i++) fbits.push_back(1'($urandom_range(0, 1)));
         rmode = $urandom_range(0, 2);
         send_a(2);
      end
      drain_a();
      chk("ovf_before", int'(ovf_a), 0);

      // Overflow: 300 ones, only 253 data bits + 2 tail symbols emitted.
      rmode = 2;
      fbits.delete();
      for (int i = 0; i < 300; i++) fbits.push_back(1'b1);
      send_a(0);
      rmode = 0;
      drain_a();
      chk("ovf_flag", int'(ovf_a), 1);
      chk("ovf_frame_len", int'(len_a), 255);

      // Reset while the fourth symbol of a frame is pending.
      fbits = '{1, 0, 1};
      model(3, 1);
      for (int i = 0; i < 3; i++) exp_a.push_back(m_sym[i]);
      fbits = '{1, 0, 1, 1};
      for (int i = 0; i < 4; i++) begin
         ifa.in_valid = 1'b1;
         ifa.in_bit   = fbits[i];
         ifa.in_last  = 1'b0;
         @(posedge clk);
         #1;
      end
      ifa.in_valid = 1'b0;
      chk("pre_rst_valid", int'(ifa.sym_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sym_valid", int'(ifa.sym_valid), 0);
      chk("mid_rst_sym", int'(ifa.sym), 0);
      chk("mid_rst_sym_last", int'(ifa.sym_last), 0);
      chk("mid_rst_frame_done", int'(done_a), 0);
      chk("mid_rst_frame_len", int'(len_a), 0);
      chk("mid_rst_overflow", int'(ovf_a), 0);
      chk("mid_rst_pending", exp_a.size(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      fbits = '{1};
      send_a(0);
      drain_a();
      chk("post_rst_frame_len", int'(len_a), 3);

      // TAIL=0 instance.
      fbits = '{1};
      run_b();
      for (int f = 0; f < 3; f++) begin
         n = $urandom_range(1, 30);
         fbits.delete();
         for (int i = 0; i < n; i++) fbits.push_back(1'($urandom_range(0, 1)));
         run_b();
      end
      chk("b_overflow", int'(ovf_b), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

endmodule

// File: doc/conv_encoder_framer.md
# conv_encoder_framer

Streaming rate-1/2 convolutional encoder that sits directly upstream of the Viterbi decoder. It accepts a frame of information bits over a valid/ready handshake and emits one 2-bit code symbol per bit, using the same generator polynomials the decoder's trellis assumes. It optionally appends K-1 zero tail bits so the frame terminates in state 0. It reports the total symbol count, which drives the decoder's `frame_len`.

## Interface
- `K`, 3: constraint length; encoder state is K-1 bits.
- `G0`, 3'b111: generator for `sym[1]`; bit 0 taps the current input bit, bit i taps the i-th previous bit.
- `G1`, 3'b101: generator for `sym[0]`, same tap convention.
- `TAIL`, 1: 1 appends K-1 zero flush bits per frame; 0 appends none.
- `MAX_SYMS`, 256: symbol capacity of the decoder frame buffer.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: an information bit is offered.
- `in_bit` in 1: the information bit.
- `in_last` in 1: the offered bit is the last data bit of the frame.
- `in_ready` out 1: the block accepts the offered bit on this edge.
- `sym_valid` out 1: `sym` holds a valid code symbol.
- `sym` out 2: code symbol `{parity(G0 & r), parity(G1 & r)}`, where `r = {state, in_bit}`.
- `sym_last` out 1: the symbol is the final symbol of the frame, tail included.
- `sym_ready` in 1: the downstream stage accepts the symbol.
- `frame_len` out 8: total symbols in the last completed frame; MAX_SYMS=256 needs 9 bits, so 8 bits holds at most 255 and capacity is clamped accordingly (see Operation).
- `frame_done` out 1: one-cycle pulse when the final symbol of a frame is accepted.
- `overflow` out 1: sticky; the frame was truncated at capacity.

## Operation
- Encoder state `st[K-2:0]`, with `st[0]` the most recent previous bit.
- On each accepted bit b: `r = {st, b}`, emit `sym`, then update `st <= {st[K-3:0], b}` (for K=3, `{st[0], b}`).
- States:
  - IDLE: `st` = 0, count = 0.
  - DATA: the first accepted bit moves IDLE to DATA. An accepted bit with `in_last` moves to TAIL if TAIL=1; otherwise it moves to IDLE and that symbol carries `sym_last`.
  - TAIL: generates K-1 symbols internally with b=0. `in_ready` = 0. The last tail symbol carries `sym_last`. After it is loaded, the state returns to IDLE.
- Symbol counter: 8 bits, incremented per symbol loaded. `frame_len` latches count+1 with the `sym_last` symbol.
- Capacity:
  - Data-bit limit L = min(MAX_SYMS, 255) − TAIL·(K−1); for the defaults, L = 253 data bits (255 symbols).
  - On acceptance of data bit number L without `in_last`, the bit is treated as last and `overflow` is set.
  - Later input bits up to and including the next `in_last` are accepted and discarded with no symbols emitted, then the state returns to IDLE.
- `overflow` clears only on reset.
- `st` and count clear on every return to IDLE. Frames are independent.

## Timing
- Output register: a single stage.
- Load condition: `load = !sym_valid || sym_ready`.
- `in_ready = load && (state is IDLE or DATA)`.
- Latency: a bit accepted at edge N produces `sym_valid`=1 with its symbol after edge N.
- Throughput: one symbol per cycle under continuous `sym_ready`.
- TAIL symbols load on consecutive cycles whenever `load` is true. The last data symbol and the first tail symbol are back-to-back.
- Backpressure: while `sym_valid` && !`sym_ready`, the values of `sym`, `sym_last` and `sym_valid` are held and nothing advances.
- Simultaneous consume and load: when `sym_ready`=1 and a new symbol loads on the same edge, `sym_valid` stays 1 and carries the new symbol.
- `frame_done` is asserted the cycle after the edge where `sym_valid && sym_ready && sym_last`.
- `frame_len` updates on the same edge as `frame_done` rises and is stable until the next frame completes.
- Reset values: `sym_valid`=0, `sym`=0, `sym_last`=0, `frame_done`=0, `frame_len`=0, `overflow`=0, state IDLE.
- Reset mid-frame: the partial frame is abandoned. No `sym_last` or `frame_done` is produced for it.

## Test plan
- Frame 0,1,0,1,0,1,0,1 (last on bit 8), TAIL=1, `sym_ready`=1: symbols 0,3,2,0,2,0,2,0,2,3. `sym_last` is set on the 10th symbol, `frame_len`=10, and one `frame_done` pulse follows.
- Impulse: single bit 1 with `in_last`: symbols 3,2,3, `frame_len`=3. With TAIL=0: a single symbol 3, `frame_len`=1.
- Backpressure: the first frame with `sym_ready` toggled 1/0 every cycle gives an identical symbol sequence, and no symbol is duplicated or dropped. `in_ready` is 0 whenever `sym_valid`=1 and `sym_ready`=0.
- Back-to-back frames: frame 1,1 (last) followed immediately by frame 1. Symbols are 3,1,1,3 then 3,2,3, showing the state cleared between frames. `frame_len` is 4 then 3.
- Overflow: 300 bits of 1 with `in_last` on bit 300. Exactly 255 symbols are emitted, `overflow`=1, `frame_len`=255, and the remaining 47 bits are accepted with no output.
- Reset: assert `rst_n`=0 after 3 symbols of a frame. All outputs go to reset values immediately. The next frame 1 (last) yields 3,2,3.
